// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the display buffer loader
package display_pkg;

    localparam int DB_ADDR_W = 11;
    localparam int DB_DATA_W = 32;
    localparam int DB_WORDS  = 2048;

    // Bit positions within the control PIO; each level change is one request.
    localparam int CTRL_WR      = 0;
    localparam int CTRL_SWAP    = 1;
    localparam int CTRL_CLR     = 2;
    localparam int CTRL_OVR_CLR = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } db_state_t;

endpackage

// File: rtl/pio_toggle_detect.sv
// rtl/pio_toggle_detect.sv - two-stage level-change detector, one pulse per toggle
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : toggle inputs (already in the clk domain)
//   pulse      : one-cycle pulse per bit whenever that bit's level changed
module pio_toggle_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Both stages reset to 0, so an input already high at reset release
    // is seen as a toggle exactly like any other level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign pulse = s1 ^ s2;

endmodule

// File: rtl/display_buffer_loader.sv
// rtl/display_buffer_loader.sv - PIO-driven loader for a double-banked display RAM
//
// Ports:
//   clk_clk, reset_reset_n      : clock and asynchronous active-low reset
//   display_buffer_addr_export  : word address within the back bank
//   display_buffer_data_export  : pixel word
//   display_buffer_ctrl_export  : toggle requests {rsvd[7:4], ovr_clr, clear, swap, write}
//   frame_start                 : one-cycle pulse from the scanner at frame start
//   ram_wr_en/addr/data         : write port into the {bank, addr} display RAM
//   disp_bank                   : bank the scanner currently reads
//   status                      : {overrun, swap_pending, clearing}
module display_buffer_loader
    import display_pkg::*;
(
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [DB_ADDR_W-1:0] display_buffer_addr_export,
    input  logic [DB_DATA_W-1:0] display_buffer_data_export,
    input  logic [7:0]           display_buffer_ctrl_export,
    input  logic                 frame_start,
    output logic                 ram_wr_en,
    output logic [DB_ADDR_W:0]   ram_wr_addr,
    output logic [DB_DATA_W-1:0] ram_wr_data,
    output logic                 disp_bank,
    output logic [2:0]           status
);

    localparam logic [DB_ADDR_W-1:0] CNT_LAST = DB_ADDR_W'(DB_WORDS - 1);

    logic [DB_ADDR_W-1:0] addr_s1;
    logic [DB_DATA_W-1:0] data_s1;
    logic [3:0]           req;
    logic [DB_ADDR_W-1:0] clr_cnt;
    db_state_t            state;
    logic                 swap_pending;
    logic                 overrun;
    logic                 ovr_set;
    logic                 swap_now;
    logic                 unused_ctrl;

    assign unused_ctrl = ^display_buffer_ctrl_export[7:4];

    pio_toggle_detect #(.WIDTH(4)) u_toggle (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .din   (display_buffer_ctrl_export[3:0]),
        .pulse (req)
    );

    // swap_pending is the registered value, so a frame_start coinciding
    // with the swap request itself cannot complete that swap.
    assign swap_now = frame_start && swap_pending && (state == ST_IDLE);

    // Requests that cannot be honoured: write/clear while clearing, or a
    // second swap while one is still waiting for its frame.
    assign ovr_set = ((state == ST_CLEAR) && (req[CTRL_WR] || req[CTRL_CLR]))
                   || (req[CTRL_SWAP] && swap_pending);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_s1      <= '0;
            data_s1      <= '0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
            overrun      <= 1'b0;
            clr_cnt      <= '0;
            state        <= ST_IDLE;
        end else begin
            addr_s1   <= display_buffer_addr_export;
            data_s1   <= display_buffer_data_export;
            ram_wr_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A simultaneous write and clear: the write goes out now,
                    // the clear sweep begins on the following cycle.
                    if (req[CTRL_WR]) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= {~disp_bank, addr_s1};
                        ram_wr_data <= data_s1;
                    end
                    if (req[CTRL_CLR]) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= {~disp_bank, clr_cnt};
                    ram_wr_data <= '0;
                    clr_cnt     <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (swap_now) begin
                disp_bank    <= ~disp_bank;
                swap_pending <= 1'b0;
            end else if (req[CTRL_SWAP]) begin
                swap_pending <= 1'b1;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (req[CTRL_OVR_CLR]) begin
                overrun <= 1'b0;
            end
        end
    end

    assign status = {overrun, swap_pending, state == ST_CLEAR};

endmodule

// File: tb/tb_display_buffer_loader.sv
// tb/tb_display_buffer_loader.sv - self-checking bench for display_buffer_loader
module tb_display_buffer_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] addr;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic        fs;
    logic        ram_wr_en;
    logic [11:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        disp_bank;
    logic [2:0]  status;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    display_buffer_loader dut (
        .clk_clk                    (clk),
        .reset_reset_n              (rst_n),
        .display_buffer_addr_export (addr),
        .display_buffer_data_export (data),
        .display_buffer_ctrl_export (ctrl),
        .frame_start                (fs),
        .ram_wr_en                  (ram_wr_en),
        .ram_wr_addr                (ram_wr_addr),
        .ram_wr_data                (ram_wr_data),
        .disp_bank                  (disp_bank),
        .status                     (status)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        logic [11:0] exp_addr;
    } vec_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  clear_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Advance to #1 after the n-th following rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle(input logic [3:0] m);
        ctrl = ctrl ^ {4'h0, m};
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = c;
        exp_q.push_back(w);
    endtask

    task automatic push_clear(input int start, input int n, input logic bank);
        for (int i = 0; i < n; i++) push_wr({~bank, 11'(i)}, 32'h0, start + i);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while ((status[0] || exp_q.size() != 0) && k < 3000) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k < 3000) n_pass++;
        else $display("FAIL %s_timeout: waited %0d cycles, %0d writes outstanding", nm, k, exp_q.size());
    endtask

    // Scoreboard: every observed write must match the oldest expectation,
    // including the exact cycle in which it appears.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (status[0]) clear_cycles++;
            if (ram_wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr %h data %h cycle %0d, none expected",
                             ram_wr_addr, ram_wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_wr_addr === e.addr && ram_wr_data === e.data && cyc == e.cyc)
                        n_pass++;
                    else
                        $display("FAIL write: got addr %h data %h cycle %0d expected addr %h data %h cycle %0d",
                                 ram_wr_addr, ram_wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    vec_t vecs[4];
    int   n0;

    initial begin
        vecs[0] = '{11'h005, 32'hDEADBEEF, 12'h805};
        vecs[1] = '{11'h000, 32'h12345678, 12'h800};
        vecs[2] = '{11'h7FF, 32'hFFFFFFFF, 12'hFFF};
        vecs[3] = '{11'h2AA, 32'hA5A5A5A5, 12'hAAA};

        rst_n = 1'b0;
        addr  = '0;
        data  = '0;
        ctrl  = '0;
        fs    = 1'b0;

        step(3);
        chk("rst_wr_en", 32'(ram_wr_en), 32'h0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'h0);
        chk("rst_wr_data", ram_wr_data, 32'h0);
        chk("rst_disp_bank", 32'(disp_bank), 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        rst_n = 1'b1;
        step(5);

        // Single writes into the back bank (bank 0 displayed -> bank 1 written).
        for (int i = 0; i < 4; i++) begin
            addr = vecs[i].addr;
            data = vecs[i].data;
            toggle(4'b0001);
            push_wr(vecs[i].exp_addr, vecs[i].data, cyc + 2);
            step(4);
        end
        chk("table_drained", exp_q.size(), 0);

        // Full back-bank clear, with a write request dropped mid-sweep.
        n0 = cyc;
        toggle(4'b0100);
        push_clear(n0 + 3, 2048, 1'b0);
        clear_cycles = 0;
        step(100);
        chk("clearing_mid", 32'(status[0]), 32'h1);
        addr = 11'h055;
        data = 32'h55555555;
        toggle(4'b0001);
        step(3);
        wait_drain("clear");
        chk("clear_cycles", clear_cycles, 2048);
        chk("overrun_after_drop", 32'(status[2]), 32'h1);
        step(3);

        toggle(4'b1000);
        step(3);
        chk("overrun_cleared", 32'(status[2]), 32'h0);

        // Swap, completed by a frame_start 10 cycles after the toggle.
        toggle(4'b0010);
        n0 = cyc;
        step(3);
        chk("swap_pending_set", 32'(status[1]), 32'h1);
        step(n0 + 10 - cyc);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        chk("swap_bank", 32'(disp_bank), 32'h1);
        chk("swap_pending_clr", 32'(status[1]), 32'h0);
        addr = 11'h033;
        data = 32'hCAFEF00D;
        toggle(4'b0001);
        push_wr(12'h033, 32'hCAFEF00D, cyc + 2);
        step(4);

        // Frame_start coinciding with swap detection must not complete it.
        toggle(4'b0010);
        step(1);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        chk("coincident_fs_bank", 32'(disp_bank), 32'h1);
        chk("coincident_fs_pending", 32'(status[1]), 32'h1);
        step(2);
        toggle(4'b0010);
        step(3);
        chk("double_swap_overrun", 32'(status[2]), 32'h1);
        chk("double_swap_pending", 32'(status[1]), 32'h1);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        chk("merged_swap_bank", 32'(disp_bank), 32'h0);
        step(2);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        chk("single_swap_only", 32'(disp_bank), 32'h0);
        toggle(4'b1000);
        step(3);
        chk("overrun_cleared2", 32'(status[2]), 32'h0);

        // Write and clear requested together: write first, then the sweep.
        addr = 11'h123;
        data = 32'h0BADF00D;
        toggle(4'b0101);
        n0 = cyc;
        push_wr(12'h923, 32'h0BADF00D, n0 + 2);
        push_clear(n0 + 3, 2048, 1'b0);
        step(2);
        chk("wr_clr_clearing", 32'(status[0]), 32'h1);
        wait_drain("wr_clr");
        chk("wr_clr_no_overrun", 32'(status[2]), 32'h0);
        step(3);

        // Reset while the sweep is at address 1000.
        toggle(4'b0100);
        n0 = cyc;
        push_clear(n0 + 3, 1000, 1'b0);
        step(n0 + 1003 - cyc);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(ram_wr_en), 32'h0);
        chk("midrst_wr_addr", 32'(ram_wr_addr), 32'h0);
        chk("midrst_wr_data", ram_wr_data, 32'h0);
        chk("midrst_status", 32'(status), 32'h0);
        chk("midrst_bank", 32'(disp_bank), 32'h0);
        chk("midrst_drained", exp_q.size(), 0);
        ctrl = '0;
        addr = '0;
        data = '0;
        step(3);
        rst_n = 1'b1;
        step(20);
        chk("post_rst_status", 32'(status), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
